// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing one split-transaction RAM port between instruction
// fetch (m0) and load/store (m1). An in-order tag queue steers each response
// back to its issuer, and fetch responses can be discarded on a pipeline flush.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  // fetch master
  input  logic                            m0_req,
  input  logic [ADDR_WIDTH-1:0]           m0_addr,
  output logic                            m0_addr_ok,
  output logic                            m0_data_ok,
  // load/store master
  input  logic                            m1_req,
  input  logic                            m1_we,
  input  logic [3:0]                      m1_wstrb,
  input  logic [ADDR_WIDTH-1:0]           m1_addr,
  input  logic [DATA_WIDTH-1:0]           m1_wdata,
  output logic                            m1_addr_ok,
  output logic                            m1_data_ok,
  output logic [DATA_WIDTH-1:0]           rdata,
  input  logic                            cancel_if,
  // slave port
  output logic                            s_req,
  output logic                            s_we,
  output logic [3:0]                      s_wstrb,
  output logic [ADDR_WIDTH-1:0]           s_addr,
  output logic [DATA_WIDTH-1:0]           s_wdata,
  input  logic                            s_addr_ok,
  input  logic                            s_data_ok,
  input  logic [DATA_WIDTH-1:0]           s_rdata,
  // status
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                            err_resp
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;

  logic            lock_q, lock_d;
  logic            lock_id_q, lock_id_d;
  logic            lock_eff;
  logic            grant;
  logic            full, empty;
  logic            accept, push, pop;
  logic            head_id, head_drop;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q;
  logic            id_q   [MAX_OUTSTANDING];
  logic            drop_q [MAX_OUTSTANDING];

  // Grant, slave request mux and response steering.
  always_comb begin
    // A lock only holds while its owner still requests; a dropped request
    // must not let the other master's transfer carry the stale owner's fields.
    lock_eff   = lock_q & (lock_id_q ? m1_req : m0_req);
    grant      = lock_eff ? lock_id_q : m1_req;
    full       = (count_q == CntW'(MAX_OUTSTANDING));
    empty      = (count_q == '0);
    s_req      = (m0_req | m1_req) & ~full & ~rst;
    s_we       = grant ? m1_we    : 1'b0;
    s_wstrb    = grant ? m1_wstrb : 4'b0000;
    s_addr     = grant ? m1_addr  : m0_addr;
    s_wdata    = grant ? m1_wdata : '0;
    accept     = s_req & s_addr_ok;
    push       = accept;
    m0_addr_ok = accept & ~grant;
    m1_addr_ok = accept & grant;
    head_id    = id_q[rd_ptr_q];
    head_drop  = drop_q[rd_ptr_q];
    pop        = s_data_ok & ~empty & ~rst;
    m0_data_ok = pop & ~head_id & ~head_drop & ~cancel_if;
    m1_data_ok = pop & head_id;
    rdata      = s_rdata;
  end

  // Lock next-state: pin the grant while a request waits for the slave.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (s_req && !s_addr_ok) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end else if (lock_q && !lock_eff) begin
      lock_d = 1'b0;
    end
  end

  // Occupancy next-state; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Lock, pointers, occupancy and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (s_data_ok && empty) err_q <= 1'b1;
    end
  end

  // Tag storage; cancel marks every id-0 slot, and a same-cycle push
  // overrides its own slot with a fresh entry that already reflects cancel.
  // Marking invalid slots is harmless since a push rewrites the drop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q[i]   <= 1'b0;
        drop_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (cancel_if && !id_q[i]) drop_q[i] <= 1'b1;
      end
      if (push) begin
        id_q[wr_ptr_q]   <= grant;
        drop_q[wr_ptr_q] <= ~grant & cancel_if;
      end
    end
  end

  assign outstanding = count_q;
  assign err_resp    = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after a rising edge,
// combinational outputs are sampled 2 ns after it, state commits on the next edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_addr_ok, m0_data_ok;
  logic        m1_req, m1_we;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_addr_ok, m1_data_ok;
  logic [31:0] rdata;
  logic        cancel_if;
  logic        s_req, s_we;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic [1:0]  outstanding;
  logic        err_resp;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
    .rdata(rdata), .cancel_if(cancel_if),
    .s_req(s_req), .s_we(s_we), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .err_resp(err_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next edge and return every input to idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    m0_req = 0; m0_addr = '0;
    m1_req = 0; m1_we = 0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
    cancel_if = 0; s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    next_cycle();
    // Reset forces request/accept/response low even with everything asserted.
    m0_req = 1; s_addr_ok = 1; s_data_ok = 1;
    settle();
    check_eq("rst_s_req", s_req, 0);
    check_eq("rst_m0_addr_ok", m0_addr_ok, 0);
    check_eq("rst_m0_data_ok", m0_data_ok, 0);
    check_eq("rst_m1_data_ok", m1_data_ok, 0);
    next_cycle();
    rst = 1'b0;
    settle();
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_err", err_resp, 0);

    // Fetch stream 0x0, 0x4, 0x8 with one-cycle response latency.
    m0_req = 1; m0_addr = 32'h0; s_addr_ok = 1;
    settle();
    check_eq("f_a0_ok", m0_addr_ok, 1);
    check_eq("f_a0_addr", s_addr, 32'h0);
    check_eq("f_a0_we", s_we, 0);
    next_cycle();
    m0_req = 1; m0_addr = 32'h4; s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h1111;
    settle();
    check_eq("f_a4_ok", m0_addr_ok, 1);
    check_eq("f_d0_ok", m0_data_ok, 1);
    check_eq("f_d0_rdata", rdata, 32'h1111);
    check_eq("f_occ1", outstanding, 1);
    next_cycle();
    m0_req = 1; m0_addr = 32'h8; s_addr_ok = 1; s_data_ok = 1;
    settle();
    check_eq("f_a8_ok", m0_addr_ok, 1);
    check_eq("f_a8_addr", s_addr, 32'h8);
    check_eq("f_d1_ok", m0_data_ok, 1);
    check_eq("f_occ2", outstanding, 1);
    next_cycle();
    s_data_ok = 1;
    settle();
    check_eq("f_d2_ok", m0_data_ok, 1);
    next_cycle();
    settle();
    check_eq("f_drained", outstanding, 0);

    // Both request: store wins, fetch follows, responses in issue order.
    m0_req = 1; m0_addr = 32'h20;
    m1_req = 1; m1_we = 1; m1_wstrb = 4'b0011; m1_addr = 32'h100; m1_wdata = 32'hdead;
    s_addr_ok = 1;
    settle();
    check_eq("p_m1_ok", m1_addr_ok, 1);
    check_eq("p_m0_ok0", m0_addr_ok, 0);
    check_eq("p_we", s_we, 1);
    check_eq("p_wstrb", s_wstrb, 4'b0011);
    check_eq("p_addr", s_addr, 32'h100);
    check_eq("p_wdata", s_wdata, 32'hdead);
    next_cycle();
    m0_req = 1; m0_addr = 32'h20; s_addr_ok = 1; s_data_ok = 1;
    settle();
    check_eq("p_m0_ok", m0_addr_ok, 1);
    check_eq("p_m0_we", s_we, 0);
    check_eq("p_m1_data", m1_data_ok, 1);
    check_eq("p_m0_data0", m0_data_ok, 0);
    next_cycle();
    s_data_ok = 1;
    settle();
    check_eq("p_m0_data", m0_data_ok, 1);
    check_eq("p_m1_data0", m1_data_ok, 0);
    next_cycle();
    settle();
    check_eq("p_drained", outstanding, 0);

    // Lock: a stalled fetch is not pre-empted by a later load.
    m0_req = 1; m0_addr = 32'h40;
    settle();
    check_eq("l_c0_addr", s_addr, 32'h40);
    check_eq("l_c0_ok", m0_addr_ok, 0);
    for (int c = 1; c < 3; c++) begin
      next_cycle();
      m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h200;
      settle();
      check_eq("l_hold_addr", s_addr, 32'h40);
      check_eq("l_hold_m1", m1_addr_ok, 0);
    end
    next_cycle();
    m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h200; s_addr_ok = 1;
    settle();
    check_eq("l_acc_m0", m0_addr_ok, 1);
    check_eq("l_acc_m1", m1_addr_ok, 0);
    check_eq("l_acc_addr", s_addr, 32'h40);
    next_cycle();
    m1_req = 1; m1_addr = 32'h200; s_addr_ok = 1; s_data_ok = 1;
    settle();
    check_eq("l_m1_ok", m1_addr_ok, 1);
    check_eq("l_m1_addr", s_addr, 32'h200);
    check_eq("l_m0_data", m0_data_ok, 1);
    next_cycle();
    s_data_ok = 1;
    settle();
    check_eq("l_m1_data", m1_data_ok, 1);
    next_cycle();
    settle();
    check_eq("l_drained", outstanding, 0);

    // Cancel with two fetches outstanding drops both responses.
    m0_req = 1; m0_addr = 32'h60; s_addr_ok = 1;
    next_cycle();
    m0_req = 1; m0_addr = 32'h64; s_addr_ok = 1;
    next_cycle();
    cancel_if = 1;
    settle();
    check_eq("c_occ2", outstanding, 2);
    for (int r = 0; r < 2; r++) begin
      next_cycle();
      s_data_ok = 1;
      settle();
      check_eq("c_m0_data", m0_data_ok, 0);
      check_eq("c_m1_data", m1_data_ok, 0);
    end
    next_cycle();
    settle();
    check_eq("c_drained", outstanding, 0);
    check_eq("c_no_err", err_resp, 0);

    // Fetch, cancel, then load: only the load response is delivered.
    m0_req = 1; m0_addr = 32'h80; s_addr_ok = 1;
    next_cycle();
    cancel_if = 1;
    next_cycle();
    m1_req = 1; m1_addr = 32'h300; s_addr_ok = 1;
    settle();
    check_eq("i_m1_ok", m1_addr_ok, 1);
    next_cycle();
    s_data_ok = 1; s_rdata = 32'haaaa;
    settle();
    check_eq("i_f_drop", m0_data_ok, 0);
    check_eq("i_f_m1", m1_data_ok, 0);
    next_cycle();
    s_data_ok = 1; s_rdata = 32'h5555;
    settle();
    check_eq("i_m1_data", m1_data_ok, 1);
    check_eq("i_rdata", rdata, 32'h5555);
    next_cycle();
    settle();
    check_eq("i_drained", outstanding, 0);

    // Full queue blocks requests, even with a pop in the same cycle.
    m0_req = 1; m0_addr = 32'ha0; s_addr_ok = 1;
    next_cycle();
    m0_req = 1; m0_addr = 32'ha4; s_addr_ok = 1;
    next_cycle();
    m0_req = 1; m0_addr = 32'ha8; s_addr_ok = 1;
    settle();
    check_eq("q_full_sreq", s_req, 0);
    check_eq("q_full_ok", m0_addr_ok, 0);
    check_eq("q_full_occ", outstanding, 2);
    next_cycle();
    m0_req = 1; m0_addr = 32'ha8; s_addr_ok = 1; s_data_ok = 1;
    settle();
    check_eq("q_pop_sreq", s_req, 0);
    check_eq("q_pop_data", m0_data_ok, 1);
    next_cycle();
    m0_req = 1; m0_addr = 32'ha8; s_addr_ok = 1; s_data_ok = 1;
    settle();
    check_eq("q_pp_ok", m0_addr_ok, 1);
    check_eq("q_pp_data", m0_data_ok, 1);
    next_cycle();
    s_data_ok = 1;
    settle();
    check_eq("q_pp_occ", outstanding, 1);
    check_eq("q_last_data", m0_data_ok, 1);
    next_cycle();
    s_data_ok = 1;
    settle();
    check_eq("q_empty_occ", outstanding, 0);
    check_eq("q_empty_m0", m0_data_ok, 0);
    check_eq("q_empty_m1", m1_data_ok, 0);
    check_eq("q_err_pre", err_resp, 0);
    next_cycle();
    settle();
    check_eq("q_err_set", err_resp, 1);
    next_cycle();
    settle();
    check_eq("q_err_sticky", err_resp, 1);

    // Reset mid-transaction discards the tag; the late response is an error.
    m0_req = 1; m0_addr = 32'hc0; s_addr_ok = 1;
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0;
    settle();
    check_eq("r_err_clr", err_resp, 0);
    check_eq("r_occ", outstanding, 0);
    next_cycle();
    s_data_ok = 1;
    settle();
    check_eq("r_late_m0", m0_data_ok, 0);
    next_cycle();
    settle();
    check_eq("r_late_err", err_resp, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
